// File: rtl/dmem_responder.sv
// Word-organised data RAM responder for the core's data bus.
// Accepts one load/store at a time, counts wait states, then returns a registered ready/error pulse.
//
// state  | meaning
// S_IDLE | waiting for ReadEn/WriteEn; latches the request and its error class
// S_WAIT | counting down the remaining wait states
// S_RESP | performs the RAM access; ready/error/read data are registered out on leaving
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] dataBusAddr,
   input  logic [31:0] dataBusWriteData,
   input  logic [3:0]  dataBusWriteMask,
   input  logic        dataBusWriteEn,
   input  logic        dataBusReadEn,
   output logic [31:0] dataBusReadData,
   output logic        dataBusReady,
   output logic        dataBusError
);

   localparam int          AW      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN    = 33'(4 * DEPTH_WORDS);
   localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    mask_q, mask_d;
   logic          we_q, we_d;
   logic          err_q, err_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          ready_q, ready_d;
   logic          error_q, error_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [32:0]   off;
   logic          req;
   logic          acc_err;

   // A borrow (addr below BASE_ADDR) makes off huge, so one compare covers both bounds.
   assign off     = {1'b0, dataBusAddr} - {1'b0, BASE_ADDR};
   assign req     = dataBusReadEn | dataBusWriteEn;
   assign acc_err = (dataBusReadEn & dataBusWriteEn) | (dataBusAddr[1:0] != 2'b00) | (off >= SPAN);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      we_d    = we_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      ready_d = 1'b0;
      error_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               idx_d   = off[AW+1:2];
               wdata_d = dataBusWriteData;
               mask_d  = dataBusWriteMask;
               we_d    = dataBusWriteEn;
               err_d   = acc_err;
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = WS_INIT;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            ready_d = 1'b1;
            error_d = err_q;
            if (!err_q && !we_q) rdata_d = mem[idx_q];
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         mask_q  <= 4'd0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         mask_q  <= mask_d;
         we_q    <= we_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
      end
   end

   // RAM is not reset; a reset forces S_IDLE, which cancels any pending write.
   always_ff @(posedge clk) begin
      if (state_q == S_RESP && we_q && !err_q) begin
         for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign dataBusReadData = rdata_q;
   assign dataBusReady    = ready_q;
   assign dataBusError    = error_q;

endmodule
